// File: rtl/synth_pkg.sv
// Shared voice-block definitions: envelope state encoding, level helpers
// and the rate encoding used by every per-voice stage.
package synth_pkg;

  // Envelope stage encoding (3-bit)
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_e;

  // Rate encoding shared by voice blocks: a rate value R moves the level by
  // one step every R+1 clock cycles, so R = 0 steps on every cycle.

  // Silence point of an offset-binary sample of the given width
  function automatic int unsigned mid_of(input int unsigned width);
    return 32'd1 << (width - 32'd1);
  endfunction

  // Full-scale level of an unsigned value of the given width
  function automatic int unsigned max_of(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/vca_scale.sv
// Voltage-controlled amplifier: scales an offset-binary sample by an
// unsigned level around the silence midpoint, registered output.
module vca_scale
  import synth_pkg::*;
#(
  parameter int WAVE_DEPTH = 8,
  parameter int ENV_DEPTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [WAVE_DEPTH-1:0] i_wave,
  input  logic [ENV_DEPTH-1:0]  i_level,
  output logic [WAVE_DEPTH-1:0] o_out
);

  localparam int unsigned           MID_U  = mid_of(WAVE_DEPTH);
  localparam logic [WAVE_DEPTH-1:0] MID    = MID_U[WAVE_DEPTH-1:0];
  localparam int                    PROD_W = WAVE_DEPTH + ENV_DEPTH + 1;

  // Floor division by 2^ENV_DEPTH; the scaled value always fits back into
  // WAVE_DEPTH bits, so the low bits carry the full signed result.
  function automatic logic [WAVE_DEPTH-1:0] scale_floor(input logic signed [PROD_W-1:0] prod);
    logic signed [PROD_W-1:0] shifted;
    shifted = prod >>> ENV_DEPTH;
    return shifted[WAVE_DEPTH-1:0];
  endfunction

  logic signed [WAVE_DEPTH:0]   w_diff;
  logic signed [PROD_W-1:0]     w_diff_x;
  logic signed [PROD_W-1:0]     w_level_x;
  logic signed [PROD_W-1:0]     w_prod;
  logic        [WAVE_DEPTH-1:0] r_out_p1;

  assign w_diff    = $signed({1'b0, i_wave}) - $signed({1'b0, MID});
  assign w_diff_x  = {{ENV_DEPTH{w_diff[WAVE_DEPTH]}}, w_diff};
  assign w_level_x = $signed({{(WAVE_DEPTH + 1){1'b0}}, i_level});
  assign w_prod    = w_diff_x * w_level_x;

  // Output register: silence on reset, scaled sample otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst) r_out_p1 <= MID;
    else       r_out_p1 <= MID + scale_floor(w_prod);
  end

  assign o_out = r_out_p1;

endmodule

// File: rtl/adsr_vca.sv
// Per-voice ADSR envelope generator driving a VCA on the wave generator's
// offset-binary output. Build option ADSR_HARD_RETRIGGER_EN: a new note
// during release restarts the attack from zero instead of the current level.
module adsr_vca
  import synth_pkg::*;
#(
  parameter int WAVE_DEPTH = 8,
  parameter int ENV_DEPTH  = 8,
  parameter int RATE_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Gate,
  input  logic [RATE_WIDTH-1:0] Attack,
  input  logic [RATE_WIDTH-1:0] Decay,
  input  logic [ENV_DEPTH-1:0]  Sustain,
  input  logic [RATE_WIDTH-1:0] Release,
  input  logic [WAVE_DEPTH-1:0] Waveform,
  output logic [ENV_DEPTH-1:0]  Envelope,
  output logic [WAVE_DEPTH-1:0] Out,
  output logic                  Active
);

  localparam int unsigned          ENV_MAX_U = max_of(ENV_DEPTH);
  localparam logic [ENV_DEPTH-1:0] ENV_MAX   = ENV_MAX_U[ENV_DEPTH-1:0];

  function automatic logic [ENV_DEPTH-1:0] sat_inc(input logic [ENV_DEPTH-1:0] v);
    return (v == ENV_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [ENV_DEPTH-1:0] sat_dec(input logic [ENV_DEPTH-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  adsr_state_e           r_state;
  adsr_state_e           w_state_nxt;
  logic                  r_gate_q;
  logic [RATE_WIDTH-1:0] r_presc;
  logic [RATE_WIDTH-1:0] w_presc_nxt;
  logic [RATE_WIDTH-1:0] w_rate;
  logic [ENV_DEPTH-1:0]  r_env;
  logic [ENV_DEPTH-1:0]  w_env_nxt;
  logic [ENV_DEPTH-1:0]  w_env_inc;
  logic                  w_rise;
  logic                  w_tick;

  assign w_rise    = Gate & ~r_gate_q;
  assign w_env_inc = sat_inc(r_env);

  // Stage rate select; idle and sustain never use the tick
  always_comb begin
    w_rate = '0;
    case (r_state)
      ST_ATTACK:  w_rate = Attack;
      ST_DECAY:   w_rate = Decay;
      ST_RELEASE: w_rate = Release;
      default:    w_rate = '0;
    endcase
  end

  assign w_tick = (r_presc == w_rate);

  // Next-state and next-level logic; a released gate outranks level compares
  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    case (r_state)
      ST_IDLE: begin
        w_env_nxt = '0;
        if (w_rise) w_state_nxt = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (!Gate) begin
          w_state_nxt = ST_RELEASE;
        end else if (w_tick) begin
          w_env_nxt = w_env_inc;
          if (w_env_inc == ENV_MAX) w_state_nxt = ST_DECAY;
        end
      end
      ST_DECAY: begin
        if (!Gate) begin
          w_state_nxt = ST_RELEASE;
        end else if (r_env <= Sustain) begin
          w_env_nxt   = Sustain;
          w_state_nxt = ST_SUSTAIN;
        end else if (w_tick) begin
          w_env_nxt = sat_dec(r_env);
        end
      end
      ST_SUSTAIN: begin
        if (!Gate) w_state_nxt = ST_RELEASE;
        else       w_env_nxt   = Sustain;
      end
      ST_RELEASE: begin
        if (w_rise) begin
          w_state_nxt = ST_ATTACK;
`ifdef ADSR_HARD_RETRIGGER_EN
          w_env_nxt   = '0;
`else
          w_env_nxt   = r_env;
`endif
        end else if (r_env == '0) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          w_env_nxt = sat_dec(r_env);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_env_nxt   = '0;
      end
    endcase
  end

  // Prescaler restarts on every stage change and after each tick
  always_comb begin
    w_presc_nxt = r_presc + 1'b1;
    if (w_state_nxt != r_state || w_tick) w_presc_nxt = '0;
  end

  // State, gate history, prescaler and level registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_gate_q <= 1'b0;
      r_presc  <= '0;
      r_env    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gate_q <= Gate;
      r_presc  <= w_presc_nxt;
      r_env    <= w_env_nxt;
    end
  end

  vca_scale #(
    .WAVE_DEPTH(WAVE_DEPTH),
    .ENV_DEPTH (ENV_DEPTH)
  ) u_vca (
    .i_clk  (Clock),
    .i_rst  (Reset),
    .i_wave (Waveform),
    .i_level(r_env),
    .o_out  (Out)
  );

  assign Envelope = r_env;
  assign Active   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adsr_vca.sv
// Directed bench for adsr_vca with hand-computed expected values.
module tb_adsr_vca;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Gate;
  logic [7:0] Attack, Decay, Release;
  logic [7:0] Sustain;
  logic [7:0] Waveform;
  logic [7:0] Envelope;
  logic [7:0] Out;
  logic       Active;

  int n_tests = 0;
  int n_fail  = 0;

  adsr_vca #(.WAVE_DEPTH(8), .ENV_DEPTH(8), .RATE_WIDTH(8)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Gate    (Gate),
    .Attack  (Attack),
    .Decay   (Decay),
    .Sustain (Sustain),
    .Release (Release),
    .Waveform(Waveform),
    .Envelope(Envelope),
    .Out     (Out),
    .Active  (Active)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset = 1'b1; Gate = 1'b1;
    Attack = 8'd0; Decay = 8'd0; Release = 8'd0; Sustain = 8'd100;
    Waveform = 8'd200;

    // Reset held with Gate high
    repeat (3) step();
    check("rst_env", Envelope, 0);
    check("rst_out", Out, 128);
    check("rst_active", Active, 0);
    Gate = 1'b0; Reset = 1'b0;
    step();
    check("idle_active", Active, 0);
    check("idle_out", Out, 128);
    Waveform = 8'd128;

    // Fast attack, then decay to sustain
    Gate = 1'b1;
    step();
    check("atk_entry_active", Active, 1);
    check("atk_entry_env", Envelope, 0);
    for (int k = 1; k <= 255; k++) begin
      step();
      check("atk_ramp", Envelope, k);
    end
    Waveform = 8'd255; Decay = 8'd3;
    step();
    check("vca_pos_full", Out, 254);
    check("dec_hold1", Envelope, 255);
    Waveform = 8'd0;
    step();
    check("vca_neg_full", Out, 0);
    Waveform = 8'd77;
    step();
    check("vca_mid_val", Out, 77);
    check("dec_hold3", Envelope, 255);
    Waveform = 8'd128;
    step();
    check("dec_first_step", Envelope, 254);
    for (int n = 0; n < 1000 && Envelope != 8'd100; n++) step();
    check("dec_to_sustain", Envelope, 100);
    repeat (10) step();
    check("sus_hold", Envelope, 100);
    check("sus_active", Active, 1);
    Sustain = 8'd90;
    step();
    check("sus_track", Envelope, 90);
    Gate = 1'b0;
    step();
    check("rel_entry_env", Envelope, 90);
    for (int n = 0; n < 300 && Active; n++) step();
    check("rel_done_active", Active, 0);
    check("rel_done_env", Envelope, 0);

    // Attack rate 3, release at 40 with rate 1
    Attack = 8'd3; Release = 8'd1; Waveform = 8'd200;
    Gate = 1'b1;
    step();
    check("a3_entry", Envelope, 0);
    repeat (3) step();
    check("a3_before_tick", Envelope, 0);
    step();
    check("a3_tick1", Envelope, 1);
    repeat (4) step();
    check("a3_tick2", Envelope, 2);
    repeat (152) step();
    check("a3_level40", Envelope, 40);
    Gate = 1'b0;
    step();
    check("r1_entry_env", Envelope, 40);
    check("r1_entry_active", Active, 1);
    step();
    check("r1_half", Envelope, 40);
    step();
    check("r1_step", Envelope, 39);
    repeat (58) step();
    check("r1_level10", Envelope, 10);
    repeat (19) step();
    check("r1_level1", Envelope, 1);
    step();
    check("r1_zero_env", Envelope, 0);
    check("r1_zero_active", Active, 1);
    step();
    check("r1_idle_active", Active, 0);
    check("r1_idle_out", Out, 128);

    // Retrigger during release at level 60
    Attack = 8'd0; Decay = 8'd0; Sustain = 8'd200; Release = 8'd255;
    Waveform = 8'd128;
    Gate = 1'b1;
    step();
    repeat (60) step();
    check("rt_level60", Envelope, 60);
    Gate = 1'b0;
    step();
    check("rt_rel_entry", Envelope, 60);
    step();
    check("rt_rel_hold", Envelope, 60);
    Gate = 1'b1;
    step();
`ifdef ADSR_HARD_RETRIGGER_EN
    check("rt_attack_entry", Envelope, 0);
    step();
    check("rt_attack_step", Envelope, 1);
`else
    check("rt_attack_entry", Envelope, 60);
    step();
    check("rt_attack_step", Envelope, 61);
`endif

    // Reset mid-note with Gate held
    Waveform = 8'd255;
    step();
    Reset = 1'b1;
    step();
    check("mid_rst_env", Envelope, 0);
    check("mid_rst_active", Active, 0);
    check("mid_rst_out", Out, 128);
    step();
    check("mid_rst_hold", Active, 0);
    Reset = 1'b0; Gate = 1'b0;
    step();
    check("post_rst_idle", Active, 0);
    Gate = 1'b1;
    step();
    check("post_rst_rise", Active, 1);
    check("post_rst_env", Envelope, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adsr_vca.md
# adsr_vca

ADSR envelope generator with a voltage-controlled-amplifier stage. It sits directly downstream of the wave generator and consumes its unsigned offset-binary `Waveform`. It produces an amplitude-shaped sample, driven by a note `Gate` and four envelope controls. One instance serves each voice, feeding the mixer.

## Interface
- `WAVE_DEPTH`, default 8: sample width; midpoint `MID = 2^(WAVE_DEPTH-1)` is silence.
- `ENV_DEPTH`, default 8: envelope level width; `ENV_MAX = 2^ENV_DEPTH - 1`.
- `RATE_WIDTH`, default 8: width of the stage rate controls.

Ports:
- `Clock`  in  1  system clock.
- `Reset`  in  1  reset Reset, synchronous, active-high; clock Clock.
- `Gate`  in  1  note held (level).
- `Attack`  in  RATE_WIDTH  attack rate; level steps by 1 every `Attack+1` cycles.
- `Decay`  in  RATE_WIDTH  decay rate, same encoding.
- `Sustain`  in  ENV_DEPTH  sustain level.
- `Release`  in  RATE_WIDTH  release rate, same encoding.
- `Waveform`  in  WAVE_DEPTH  unsigned offset-binary input sample.
- `Envelope`  out  ENV_DEPTH  current envelope level (registered).
- `Out`  out  WAVE_DEPTH  scaled sample, offset-binary.
- `Active`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- `gate_q` is a registered copy of `Gate`. Rise = `Gate & ~gate_q`.
- Prescaler: a RATE_WIDTH counter compared against the current stage's rate.
  - On a match it produces a tick and clears itself.
  - It is cleared on every state change.
  - Rate controls are sampled live each cycle.
- IDLE: `Envelope` = 0. Rise → ATTACK.
- ATTACK: on each tick `Envelope += 1`.
  - On the tick that reaches `ENV_MAX`, go to DECAY.
  - `Gate` = 0 → RELEASE immediately, keeping the current level.
- DECAY:
  - If `Envelope <= Sustain`, set `Envelope <= Sustain` and go to SUSTAIN. No tick is required.
  - Otherwise `Envelope -= 1` on each tick.
  - `Gate` = 0 → RELEASE.
- SUSTAIN: `Envelope <= Sustain` every cycle, tracking live changes. `Gate` = 0 → RELEASE.
- RELEASE:
  - If `Envelope == 0`, go to IDLE.
  - Otherwise `Envelope -= 1` on each tick.
  - Rise → ATTACK (see Configuration).
- Priority in A/D/S: `Gate` = 0 beats every level-driven transition.
- Arithmetic: levels saturate, never wrapping below 0 or above `ENV_MAX`.
- VCA: `Out = MID + (((Waveform - MID) * Envelope) >>> ENV_DEPTH)`.
  - The difference is signed WAVE_DEPTH+1 bits.
  - The product is signed WAVE_DEPTH+ENV_DEPTH+1 bits, with an arithmetic floor shift.
  - The result always fits in WAVE_DEPTH bits; no clamp is needed.

## Timing
- Reset values: state IDLE, `Envelope` 0, `Out` = MID, `Active` 0, `gate_q` 0, prescaler 0.
- Reset mid-note forces these values on the next edge, regardless of `Gate`.
- Rise is detected on the edge that samples `Gate` = 1 with `gate_q` = 0. The state is ATTACK after that edge.
- With rate 0, level changes start on the next edge.
- Stage-to-stage transitions take effect on the same edge as the triggering tick or compare.
- `Out` has a latency of 1 cycle: it is registered from the current `Waveform` and registered `Envelope`.
- `Active` is combinational from the state register.

## Configuration
- `ADSR_HARD_RETRIGGER_EN` defined: a rise in RELEASE clears `Envelope` to 0 on the same edge as entering ATTACK.
- `ADSR_HARD_RETRIGGER_EN` undefined (default): ATTACK resumes from the current level (legato, click-free).
- IDLE behaviour is identical either way, since the level is already 0.

## Structure
- Shared package/include `synth_pkg` holds:
  - state encoding constants (3-bit),
  - the `MID` and `ENV_MAX` helper expressions,
  - the rate encoding note shared with other voice blocks.
- Sub-module `vca_scale` is natural: the signed multiply, shift and output register, reusable by the mixer's master volume.

## Test plan
- Reset with `Gate` = 1 held → `Envelope` = 0, `Out` = 128, `Active` = 0 while `Reset` is high; ATTACK begins only after a fresh rise.
- `Attack` = 0, `Decay` = 0, `Sustain` = 100, `Gate` rises and is held:
  - `Envelope` = 255 and state DECAY 255 edges after the ATTACK-entry edge;
  - then it decays to 100 and holds in SUSTAIN.
- `Attack` = 3: `Envelope` increments once every 4 cycles; `Gate` dropped at level 40 → RELEASE from 40 with no jump.
- `Release` = 1 from level 10 → reaches 0 after 20 cycles, then IDLE and `Active` = 0 one edge later.
- VCA with `Envelope` = 255:
  - `Waveform` = 255 → `Out` = 254;
  - `Waveform` = 0 → `Out` = 0;
  - `Envelope` = 0, any `Waveform` → `Out` = 128.
- Rise during RELEASE at level 60 → next ATTACK step gives 61 by default, or 1 with `ADSR_HARD_RETRIGGER_EN`.
